// File: rtl/alu_sequencer.sv
// alu_sequencer: four-phase (Q1..Q4) instruction-cycle controller. It latches an instruction,
// decodes it to an ALU op and sequences regfile read, execute, W/F/STATUS writeback and skips.
// Optional feature macro: ALU_SEQ_PERF_EN enables the executed/skipped instruction counters.
module alu_sequencer #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [13:0]       instr,
  input  logic              instr_valid,
  input  logic              stall,
  input  logic [7:0]        alu_result,
  output logic [1:0]        q_phase,
  output logic [3:0]        alu_op,
  output logic              alu_status_wr_en,
  output logic              lf_sel,
  output logic [7:0]        literal,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_rd_en,
  output logic              rf_wr_en,
  output logic              w_wr_en,
  output logic              pc_inc,
  output logic              skip_active,
  output logic              illegal_op,
  output logic [15:0]       perf_instr_cnt,
  output logic [15:0]       perf_skip_cnt
);

  localparam logic [3:0] ALU_OP_NOP    = 4'd0;
  localparam logic [3:0] ALU_OP_ADD    = 4'd1;
  localparam logic [3:0] ALU_OP_SUB    = 4'd2;
  localparam logic [3:0] ALU_OP_AND    = 4'd3;
  localparam logic [3:0] ALU_OP_XOR    = 4'd4;
  localparam logic [3:0] ALU_OP_CLR    = 4'd5;
  localparam logic [3:0] ALU_OP_COM    = 4'd6;
  localparam logic [3:0] ALU_OP_INC    = 4'd7;
  localparam logic [3:0] ALU_OP_DEC    = 4'd8;
  localparam logic [3:0] ALU_OP_PASSLF = 4'd9;
  localparam logic [3:0] ALU_OP_PASSW  = 4'd10;
  localparam logic [3:0] ALU_OP_RLF    = 4'd11;
  localparam logic [3:0] ALU_OP_RRF    = 4'd12;
  localparam logic [3:0] ALU_OP_SWAPF  = 4'd13;

  typedef enum logic [1:0] {PH_Q1 = 2'd0, PH_Q2 = 2'd1, PH_Q3 = 2'd2, PH_Q4 = 2'd3} phase_e;

  typedef struct packed {
    logic [3:0] op;
    logic       lit;
    logic       rd;
    logic       wf;
    logic       ww;
    logic       st;
    logic       sz;
    logic       ill;
  } dec_t;

  function automatic dec_t decode(input logic [13:0] iw);
    dec_t r;
    logic byte_op;
    r = '0;
    casez (iw[13:8])
      6'b000000: begin r.op = iw[7] ? ALU_OP_PASSW : ALU_OP_NOP; r.wf = iw[7]; end
      6'b000001: begin r.op = ALU_OP_CLR;    r.st = 1'b1; end
      6'b000010: begin r.op = ALU_OP_SUB;    r.st = 1'b1; end
      6'b000011: begin r.op = ALU_OP_DEC;    r.st = 1'b1; end
      6'b000101: begin r.op = ALU_OP_AND;    r.st = 1'b1; end
      6'b000110: begin r.op = ALU_OP_XOR;    r.st = 1'b1; end
      6'b000111: begin r.op = ALU_OP_ADD;    r.st = 1'b1; end
      6'b001000: begin r.op = ALU_OP_PASSLF; r.st = 1'b1; end
      6'b001001: begin r.op = ALU_OP_COM;    r.st = 1'b1; end
      6'b001010: begin r.op = ALU_OP_INC;    r.st = 1'b1; end
      6'b001011: begin r.op = ALU_OP_DEC;    r.sz = 1'b1; end
      6'b001100: begin r.op = ALU_OP_RRF;    r.st = 1'b1; end
      6'b001101: begin r.op = ALU_OP_RLF;    r.st = 1'b1; end
      6'b001110: begin r.op = ALU_OP_SWAPF; end
      6'b001111: begin r.op = ALU_OP_INC;    r.sz = 1'b1; end
      6'b1100??: begin r.op = ALU_OP_PASSLF; r.lit = 1'b1; end
      6'b111001: begin r.op = ALU_OP_AND;    r.lit = 1'b1; r.st = 1'b1; end
      6'b111010: begin r.op = ALU_OP_XOR;    r.lit = 1'b1; r.st = 1'b1; end
      6'b11110?: begin r.op = ALU_OP_SUB;    r.lit = 1'b1; r.st = 1'b1; end
      6'b11111?: begin r.op = ALU_OP_ADD;    r.lit = 1'b1; r.st = 1'b1; end
      default:   begin r.ill = 1'b1; end
    endcase
    byte_op = (iw[13:12] == 2'b00) && (iw[11:8] != 4'h0) && !r.ill;
    // CLRW is the only byte-oriented op that never reads its f operand
    if (byte_op) begin
      r.rd = !((r.op == ALU_OP_CLR) && !iw[7]);
      r.wf = iw[7];
      r.ww = !iw[7];
    end else if (r.lit) begin
      r.ww = 1'b1;
    end else begin
      r.rd = 1'b0;
    end
    return r;
  endfunction

  phase_e            phase_q, phase_d;
  logic [13:0]       instr_q, instr_d;
  logic              bubble_q, bubble_d;
  logic              cur_skip_q, cur_skip_d;
  logic              skip_pend_q, skip_pend_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic              lf_sel_q, lf_sel_d;
  logic [7:0]        literal_q, literal_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic              rf_rd_en_q, rf_rd_en_d;
  logic              rf_wr_en_q, rf_wr_en_d;
  logic              w_wr_en_q, w_wr_en_d;
  logic              status_wr_q, status_wr_d;
  logic              pc_inc_q, pc_inc_d;
  logic              skip_active_q, skip_active_d;
  logic              illegal_q, illegal_d;
  logic              enter_q4_s, leave_q4_s;
  phase_e            phase_n_s;
  dec_t              dec_s;

  // Next-state and registered-output computation; everything freezes while stall is high.
  always_comb begin
    phase_d     = phase_q;
    instr_d     = instr_q;
    bubble_d    = bubble_q;
    cur_skip_d  = cur_skip_q;
    skip_pend_d = skip_pend_q;
    enter_q4_s  = 1'b0;
    leave_q4_s  = 1'b0;
    case (phase_q)
      PH_Q1:   phase_n_s = PH_Q2;
      PH_Q2:   phase_n_s = PH_Q3;
      PH_Q3:   phase_n_s = PH_Q4;
      PH_Q4:   phase_n_s = PH_Q1;
      default: phase_n_s = PH_Q1;
    endcase
    if (!stall) begin
      phase_d    = phase_n_s;
      enter_q4_s = (phase_q == PH_Q3);
      leave_q4_s = (phase_q == PH_Q4);
      if (phase_q == PH_Q1) begin
        instr_d    = instr_valid ? instr : 14'h0000;
        bubble_d   = !instr_valid;
        cur_skip_d = instr_valid && skip_pend_q;
      end else begin
        instr_d    = instr_q;
      end
    end else begin
      phase_d = phase_q;
    end

    dec_s = decode(instr_d);

    // A skipped cycle clears the flag and can never re-arm it, even if it is itself a skip op
    if (leave_q4_s && cur_skip_q) begin
      skip_pend_d = 1'b0;
    end else if (leave_q4_s && dec_s.sz && (alu_result == 8'h00)) begin
      skip_pend_d = 1'b1;
    end else begin
      skip_pend_d = skip_pend_q;
    end

    alu_op_d      = cur_skip_d ? ALU_OP_NOP : dec_s.op;
    lf_sel_d      = dec_s.lit && !cur_skip_d;
    literal_d     = instr_d[7:0];
    rf_addr_d     = instr_d[ADDR_W-1:0];
    rf_rd_en_d    = (phase_d == PH_Q2) && dec_s.rd && !cur_skip_d;
    rf_wr_en_d    = enter_q4_s && dec_s.wf && !cur_skip_d;
    w_wr_en_d     = enter_q4_s && dec_s.ww && !cur_skip_d;
    status_wr_d   = enter_q4_s && dec_s.st && !cur_skip_d;
    illegal_d     = enter_q4_s && dec_s.ill && !cur_skip_d;
    pc_inc_d      = enter_q4_s && !bubble_d;
    skip_active_d = (phase_d == PH_Q1) ? skip_pend_d : cur_skip_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= PH_Q1;
      instr_q       <= 14'h0000;
      bubble_q      <= 1'b0;
      cur_skip_q    <= 1'b0;
      skip_pend_q   <= 1'b0;
      alu_op_q      <= ALU_OP_NOP;
      lf_sel_q      <= 1'b0;
      literal_q     <= 8'h00;
      rf_addr_q     <= '0;
      rf_rd_en_q    <= 1'b0;
      rf_wr_en_q    <= 1'b0;
      w_wr_en_q     <= 1'b0;
      status_wr_q   <= 1'b0;
      pc_inc_q      <= 1'b0;
      skip_active_q <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      instr_q       <= instr_d;
      bubble_q      <= bubble_d;
      cur_skip_q    <= cur_skip_d;
      skip_pend_q   <= skip_pend_d;
      alu_op_q      <= alu_op_d;
      lf_sel_q      <= lf_sel_d;
      literal_q     <= literal_d;
      rf_addr_q     <= rf_addr_d;
      rf_rd_en_q    <= rf_rd_en_d;
      rf_wr_en_q    <= rf_wr_en_d;
      w_wr_en_q     <= w_wr_en_d;
      status_wr_q   <= status_wr_d;
      pc_inc_q      <= pc_inc_d;
      skip_active_q <= skip_active_d;
      illegal_q     <= illegal_d;
    end
  end

  assign q_phase          = phase_q;
  assign alu_op           = alu_op_q;
  assign alu_status_wr_en = status_wr_q;
  assign lf_sel           = lf_sel_q;
  assign literal          = literal_q;
  assign rf_addr          = rf_addr_q;
  assign rf_rd_en         = rf_rd_en_q;
  assign rf_wr_en         = rf_wr_en_q;
  assign w_wr_en          = w_wr_en_q;
  assign pc_inc           = pc_inc_q;
  assign skip_active      = skip_active_q;
  assign illegal_op       = illegal_q;

`ifdef ALU_SEQ_PERF_EN
  logic [15:0] perf_instr_q, perf_instr_d;
  logic [15:0] perf_skip_q, perf_skip_d;

  // Counters step once on entry to Q4, so a stalled Q4 never double counts.
  always_comb begin
    perf_instr_d = perf_instr_q;
    perf_skip_d  = perf_skip_q;
    if (enter_q4_s && cur_skip_q) begin
      perf_skip_d = perf_skip_q + 16'd1;
    end else if (enter_q4_s && !bubble_q) begin
      perf_instr_d = perf_instr_q + 16'd1;
    end else begin
      perf_instr_d = perf_instr_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_instr_q <= 16'h0000;
      perf_skip_q  <= 16'h0000;
    end else begin
      perf_instr_q <= perf_instr_d;
      perf_skip_q  <= perf_skip_d;
    end
  end

  assign perf_instr_cnt = perf_instr_q;
  assign perf_skip_cnt  = perf_skip_q;
`else
  assign perf_instr_cnt = 16'h0000;
  assign perf_skip_cnt  = 16'h0000;
`endif

endmodule
